// File: rtl/plab3_mem_blocking_cache_alt_ctrl.sv
// rtl/plab3_mem_blocking_cache_alt_ctrl.sv - control unit for the 2-way write-back blocking cache
module plab3_mem_blocking_cache_alt_ctrl #(
  parameter int unsigned size           = 256,
  parameter int unsigned p_idx_shamt    = 0,
  parameter int unsigned p_opaque_nbits = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cachereq_val_i,
  output logic                      cachereq_rdy_o,
  output logic                      cacheresp_val_o,
  input  logic                      cacheresp_rdy_i,
  output logic                      memreq_val_o,
  input  logic                      memreq_rdy_i,
  input  logic                      memresp_val_i,
  output logic                      memresp_rdy_o,
  input  logic [2:0]                cachereq_type_i,
  input  logic [31:0]               cachereq_addr_i,
  input  logic [p_opaque_nbits-1:0] cachereq_opaque_i,
  output logic [p_opaque_nbits-1:0] cacheresp_opaque_o,
  input  logic                      tag_match_0_i,
  input  logic                      tag_match_1_i,
  output logic [1:0]                amo_sel_o,
  output logic                      cachereq_en_o,
  output logic                      memresp_en_o,
  output logic                      is_refill_o,
  output logic                      tag_array_0_wen_o,
  output logic                      tag_array_0_ren_o,
  output logic                      tag_array_1_wen_o,
  output logic                      tag_array_1_ren_o,
  output logic                      way_sel_o,
  output logic                      data_array_wen_o,
  output logic                      data_array_ren_o,
  output logic [15:0]               data_array_wben_o,
  output logic                      read_data_reg_en_o,
  output logic                      read_tag_reg_en_o,
  output logic [1:0]                read_byte_sel_o,
  output logic [2:0]                memreq_type_o,
  output logic [2:0]                cacheresp_type_o
);

  // two ways of 16-byte lines per set
  localparam int unsigned NSETS = size / 32;

  typedef enum logic [3:0] {
    S_IDLE, S_TCHK, S_INIT, S_RD, S_WR, S_AMOR, S_AMOW,
    S_EVP, S_EVQ, S_EVW, S_RFQ, S_RFW, S_RFU, S_WAIT
  } state_t;

  state_t                       state_q, state_d;
  logic                         way_q, way_d;
  logic [1:0][NSETS-1:0]        valid_q, valid_d;
  logic [1:0][NSETS-1:0]        dirty_q, dirty_d;
  logic [NSETS-1:0]             lru_q, lru_d;

  logic [2:0]  idx;
  logic        is_write, is_init, is_amo;
  logic        hit0, hit1, hit, victim, tchk_way;
  logic [15:0] word_wben;
  logic [2:0]  amo_t;
  logic        unused_addr;

  assign idx       = cachereq_addr_i[4+p_idx_shamt +: 3];
  assign is_write  = (cachereq_type_i == 3'd1);
  assign is_init   = (cachereq_type_i == 3'd2);
  assign is_amo    = (cachereq_type_i == 3'd3) || (cachereq_type_i == 3'd4) ||
                     (cachereq_type_i == 3'd5);
  assign hit0      = valid_q[0][idx] & tag_match_0_i;
  assign hit1      = valid_q[1][idx] & tag_match_1_i;
  assign hit       = hit0 | hit1;
  // fill an empty way first (way 0 before way 1), otherwise evict the LRU way
  assign victim    = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign tchk_way  = (!is_init && hit) ? !hit0 : victim;
  assign word_wben = 16'h000F << {cachereq_addr_i[3:2], 2'b00};
  assign amo_t     = cachereq_type_i - 3'd2;
  assign unused_addr = ^cachereq_addr_i;

  // state, way and per-line/per-set bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      way_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
    end
  end

  // next-state, bookkeeping updates and datapath controls; all outputs held low in reset
  always_comb begin
    state_d            = state_q;
    way_d              = way_q;
    valid_d            = valid_q;
    dirty_d            = dirty_q;
    lru_d              = lru_q;
    cachereq_rdy_o     = 1'b0;
    cacheresp_val_o    = 1'b0;
    memreq_val_o       = 1'b0;
    memresp_rdy_o      = 1'b0;
    amo_sel_o          = 2'd0;
    cachereq_en_o      = 1'b0;
    memresp_en_o       = 1'b0;
    is_refill_o        = 1'b0;
    tag_array_0_wen_o  = 1'b0;
    tag_array_0_ren_o  = 1'b0;
    tag_array_1_wen_o  = 1'b0;
    tag_array_1_ren_o  = 1'b0;
    way_sel_o          = 1'b0;
    data_array_wen_o   = 1'b0;
    data_array_ren_o   = 1'b0;
    data_array_wben_o  = 16'h0000;
    read_data_reg_en_o = 1'b0;
    read_tag_reg_en_o  = 1'b0;
    read_byte_sel_o    = 2'd0;
    memreq_type_o      = 3'd0;
    cacheresp_type_o   = 3'd0;
    cacheresp_opaque_o = '0;
    if (!reset_i) begin
      way_sel_o          = way_q;
      read_byte_sel_o    = cachereq_addr_i[3:2];
      cacheresp_type_o   = cachereq_type_i;
      cacheresp_opaque_o = cachereq_opaque_i;
      case (state_q)
        S_IDLE: begin
          cachereq_rdy_o = 1'b1;
          if (cachereq_val_i) begin
            cachereq_en_o = 1'b1;
            state_d       = S_TCHK;
          end
        end
        S_TCHK: begin
          tag_array_0_ren_o = 1'b1;
          tag_array_1_ren_o = 1'b1;
          way_sel_o         = tchk_way;
          way_d             = tchk_way;
          if (is_init)                                    state_d = S_INIT;
          else if (hit && is_write)                       state_d = S_WR;
          else if (hit && is_amo)                         state_d = S_AMOR;
          else if (hit)                                   state_d = S_RD;
          else if (valid_q[victim][idx] && dirty_q[victim][idx]) state_d = S_EVP;
          else                                            state_d = S_RFQ;
        end
        S_INIT: begin
          tag_array_0_wen_o      = ~way_q;
          tag_array_1_wen_o      = way_q;
          data_array_wen_o       = 1'b1;
          data_array_wben_o      = word_wben;
          valid_d[way_q][idx]    = 1'b1;
          dirty_d[way_q][idx]    = 1'b0;
          lru_d[idx]             = ~way_q;
          state_d                = S_WAIT;
        end
        S_RD: begin
          data_array_ren_o   = 1'b1;
          read_data_reg_en_o = 1'b1;
          lru_d[idx]         = ~way_q;
          state_d            = S_WAIT;
        end
        S_WR: begin
          data_array_wen_o    = 1'b1;
          data_array_wben_o   = word_wben;
          dirty_d[way_q][idx] = 1'b1;
          lru_d[idx]          = ~way_q;
          state_d             = S_WAIT;
        end
        S_AMOR: begin
          data_array_ren_o   = 1'b1;
          read_data_reg_en_o = 1'b1;
          state_d            = S_AMOW;
        end
        S_AMOW: begin
          // read register keeps the pre-AMO value for the response
          amo_sel_o           = amo_t[1:0];
          data_array_wen_o    = 1'b1;
          data_array_wben_o   = word_wben;
          dirty_d[way_q][idx] = 1'b1;
          lru_d[idx]          = ~way_q;
          state_d             = S_WAIT;
        end
        S_EVP: begin
          tag_array_0_ren_o  = ~way_q;
          tag_array_1_ren_o  = way_q;
          data_array_ren_o   = 1'b1;
          read_data_reg_en_o = 1'b1;
          read_tag_reg_en_o  = 1'b1;
          state_d            = S_EVQ;
        end
        S_EVQ: begin
          memreq_val_o  = 1'b1;
          memreq_type_o = 3'd1;
          if (memreq_rdy_i) state_d = S_EVW;
        end
        S_EVW: begin
          memresp_rdy_o = 1'b1;
          if (memresp_val_i) state_d = S_RFQ;
        end
        S_RFQ: begin
          memreq_val_o  = 1'b1;
          memreq_type_o = 3'd0;
          if (memreq_rdy_i) state_d = S_RFW;
        end
        S_RFW: begin
          memresp_rdy_o = 1'b1;
          if (memresp_val_i) begin
            memresp_en_o = 1'b1;
            state_d      = S_RFU;
          end
        end
        S_RFU: begin
          is_refill_o         = 1'b1;
          data_array_wen_o    = 1'b1;
          data_array_wben_o   = 16'hFFFF;
          tag_array_0_wen_o   = ~way_q;
          tag_array_1_wen_o   = way_q;
          valid_d[way_q][idx] = 1'b1;
          dirty_d[way_q][idx] = 1'b0;
          if (is_write)    state_d = S_WR;
          else if (is_amo) state_d = S_AMOR;
          else             state_d = S_RD;
        end
        S_WAIT: begin
          cacheresp_val_o = 1'b1;
          if (cacheresp_rdy_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plab3_mem_blocking_cache_alt_ctrl.sv
// tb/tb_plab3_mem_blocking_cache_alt_ctrl.sv - directed bench for the cache control unit
module tb_plab3_mem_blocking_cache_alt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [2:0]  cachereq_type, memreq_type, cacheresp_type;
  logic [31:0] cachereq_addr;
  logic [7:0]  cachereq_opaque, cacheresp_opaque;
  logic        tag_match_0, tag_match_1;
  logic [1:0]  amo_sel, read_byte_sel;
  logic        cachereq_en, memresp_en, is_refill;
  logic        tag_array_0_wen, tag_array_0_ren, tag_array_1_wen, tag_array_1_ren;
  logic        way_sel, data_array_wen, data_array_ren, read_data_reg_en, read_tag_reg_en;
  logic [15:0] data_array_wben;

  plab3_mem_blocking_cache_alt_ctrl dut (
    .clk_i(clk), .reset_i(reset),
    .cachereq_val_i(cachereq_val), .cachereq_rdy_o(cachereq_rdy),
    .cacheresp_val_o(cacheresp_val), .cacheresp_rdy_i(cacheresp_rdy),
    .memreq_val_o(memreq_val), .memreq_rdy_i(memreq_rdy),
    .memresp_val_i(memresp_val), .memresp_rdy_o(memresp_rdy),
    .cachereq_type_i(cachereq_type), .cachereq_addr_i(cachereq_addr),
    .cachereq_opaque_i(cachereq_opaque), .cacheresp_opaque_o(cacheresp_opaque),
    .tag_match_0_i(tag_match_0), .tag_match_1_i(tag_match_1),
    .amo_sel_o(amo_sel), .cachereq_en_o(cachereq_en), .memresp_en_o(memresp_en),
    .is_refill_o(is_refill),
    .tag_array_0_wen_o(tag_array_0_wen), .tag_array_0_ren_o(tag_array_0_ren),
    .tag_array_1_wen_o(tag_array_1_wen), .tag_array_1_ren_o(tag_array_1_ren),
    .way_sel_o(way_sel), .data_array_wen_o(data_array_wen), .data_array_ren_o(data_array_ren),
    .data_array_wben_o(data_array_wben), .read_data_reg_en_o(read_data_reg_en),
    .read_tag_reg_en_o(read_tag_reg_en), .read_byte_sel_o(read_byte_sel),
    .memreq_type_o(memreq_type), .cacheresp_type_o(cacheresp_type)
  );

  int n_vec = 0;
  int n_bad = 0;

  int          r_lat, r_nreq, r_nwr, r_err;
  logic [2:0]  r_ty0, r_ty1, r_rtype;
  logic        r_wsel, r_refill, r_rdreg, r_done;
  logic [1:0]  r_amo, r_tagw;
  logic [15:0] r_wben;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one request from accept to response handshake; rs/ms = cycles to stall cacheresp_rdy/memreq_rdy
  task automatic txn(input logic [2:0] t, input logic [31:0] a, input logic m0, input logic m1,
                     input int rs, input int ms);
    int hold, rh;
    logic [2:0] held;
    r_lat = 0; r_nreq = 0; r_nwr = 0; r_err = 0; r_ty0 = 3'd7; r_ty1 = 3'd7; r_rtype = 3'd7;
    r_wsel = 1'bx; r_refill = 0; r_rdreg = 1'bx; r_amo = 2'bxx; r_tagw = 2'b00; r_wben = 16'h0;
    r_done = 0; hold = 0; rh = 0; held = 3'd0;
    @(negedge clk);
    cachereq_val = 1; cachereq_type = t; cachereq_addr = a;
    tag_match_0 = m0; tag_match_1 = m1; cacheresp_rdy = 0; memreq_rdy = 0;
    #1;
    if (!(cachereq_rdy && cachereq_en)) r_err++;
    for (int c = 1; c <= 80 && !r_done; c++) begin
      @(negedge clk);
      cachereq_val = 0;
      if (c == 1) r_wsel = way_sel;
      if (cachereq_rdy) r_err++;
      if (tag_array_0_wen || tag_array_1_wen) r_tagw = {tag_array_1_wen, tag_array_0_wen};
      if (data_array_wen) begin
        if (data_array_wben == 16'hFFFF) r_refill = 1;
        else begin
          r_nwr++; r_wben = data_array_wben; r_amo = amo_sel; r_rdreg = read_data_reg_en;
        end
      end
      if (memreq_val) begin
        if (hold == 0) held = memreq_type;
        else if (memreq_type !== held) r_err++;
        if (hold < ms) begin
          memreq_rdy = 0; hold++;
        end else begin
          memreq_rdy = 1;
          if (r_nreq == 0) r_ty0 = memreq_type; else r_ty1 = memreq_type;
          r_nreq++; hold = 0;
        end
      end else begin
        if (hold > 0) r_err++;
        memreq_rdy = 0;
      end
      if (cacheresp_val) begin
        if (r_lat == 0) begin r_lat = c; r_rtype = cacheresp_type; end
        else if (cacheresp_type !== r_rtype) r_err++;
        if (rh < rs) begin cacheresp_rdy = 0; rh++; end
        else begin cacheresp_rdy = 1; r_done = 1; end
      end else if (rh > 0) r_err++;
    end
    chk("txn_completed", r_done, 1);
  endtask

  initial begin
    reset = 1; cachereq_val = 1; cachereq_type = 3'd5; cachereq_addr = 32'hFFFF_FFFC;
    cachereq_opaque = 8'hA5; tag_match_0 = 1; tag_match_1 = 1;
    cacheresp_rdy = 1; memreq_rdy = 1; memresp_val = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_all_outputs_low",
        |{cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy, amo_sel, cachereq_en,
          memresp_en, is_refill, tag_array_0_wen, tag_array_0_ren, tag_array_1_wen,
          tag_array_1_ren, way_sel, data_array_wen, data_array_ren, data_array_wben,
          read_data_reg_en, read_tag_reg_en, read_byte_sel, memreq_type, cacheresp_type,
          cacheresp_opaque}, 0);
    reset = 0; cachereq_val = 0;
    #1;
    chk("idle_rdy", cachereq_rdy, 1);
    chk("opaque_pass", cacheresp_opaque, 32'hA5);

    // init 0x100 into empty set 0 -> way 0, word 0
    txn(3'd2, 32'h100, 0, 0, 0, 0);
    chk("init_lat", r_lat, 3); chk("init_nreq", r_nreq, 0);
    chk("init_tagw", r_tagw, 2'b01); chk("init_wben", r_wben, 16'h000F); chk("init_err", r_err, 0);

    // read hit on way 0
    txn(3'd0, 32'h100, 1, 0, 0, 0);
    chk("rdhit_lat", r_lat, 3); chk("rdhit_nreq", r_nreq, 0);
    chk("rdhit_way", r_wsel, 0); chk("rdhit_nwr", r_nwr, 0);

    // cold read 0x1000 -> fills empty way 1
    txn(3'd0, 32'h1000, 0, 0, 0, 0);
    chk("cold_lat", r_lat, 6); chk("cold_nreq", r_nreq, 1); chk("cold_type", r_ty0, 0);
    chk("cold_way", r_wsel, 1); chk("cold_refill", r_refill, 1); chk("cold_tagw", r_tagw, 2'b10);

    txn(3'd0, 32'h1000, 0, 1, 0, 0);
    chk("rehit_lat", r_lat, 3); chk("rehit_nreq", r_nreq, 0); chk("rehit_way", r_wsel, 1);

    // write hit word 2 of way 0 -> dirty, lru points to way 1
    txn(3'd1, 32'h108, 1, 0, 0, 0);
    chk("wr_lat", r_lat, 3); chk("wr_wben", r_wben, 16'h0F00);
    chk("wr_amo", r_amo, 0); chk("wr_nwr", r_nwr, 1);

    // miss: LRU victim way 1 is clean -> no eviction
    txn(3'd0, 32'h080, 0, 0, 0, 0);
    chk("clean_lat", r_lat, 6); chk("clean_nreq", r_nreq, 1); chk("clean_way", r_wsel, 1);

    // miss: LRU victim way 0 is dirty -> evict then refill
    txn(3'd0, 32'h000, 0, 0, 0, 0);
    chk("dirty_lat", r_lat, 9); chk("dirty_nreq", r_nreq, 2);
    chk("dirty_ty0", r_ty0, 1); chk("dirty_ty1", r_ty1, 0); chk("dirty_way", r_wsel, 0);

    // AMOs on set 0 way 1
    txn(3'd3, 32'h204, 0, 0, 0, 0);
    chk("amoadd_lat", r_lat, 7); chk("amoadd_nreq", r_nreq, 1); chk("amoadd_way", r_wsel, 1);
    chk("amoadd_sel", r_amo, 1); chk("amoadd_wben", r_wben, 16'h00F0);
    chk("amoadd_rdreg", r_rdreg, 0); chk("amoadd_rtype", r_rtype, 3);
    txn(3'd4, 32'h20C, 0, 1, 0, 0);
    chk("amoand_lat", r_lat, 4); chk("amoand_nreq", r_nreq, 0);
    chk("amoand_sel", r_amo, 2); chk("amoand_wben", r_wben, 16'hF000);
    txn(3'd5, 32'h200, 0, 1, 0, 0);
    chk("amoor_lat", r_lat, 4); chk("amoor_sel", r_amo, 3); chk("amoor_wben", r_wben, 16'h000F);

    // type 6 behaves as a read
    txn(3'd6, 32'h000, 1, 0, 0, 0);
    chk("t6_lat", r_lat, 3); chk("t6_nwr", r_nwr, 0); chk("t6_rtype", r_rtype, 6);

    // response back-pressure for 5 cycles
    txn(3'd0, 32'h000, 1, 0, 5, 0);
    chk("rstall_lat", r_lat, 3); chk("rstall_err", r_err, 0);

    // memory back-pressure 4 cycles on both eviction and refill (victim way 1 dirty)
    txn(3'd0, 32'h380, 0, 0, 0, 4);
    chk("mstall_lat", r_lat, 17); chk("mstall_nreq", r_nreq, 2);
    chk("mstall_ty0", r_ty0, 1); chk("mstall_ty1", r_ty1, 0);
    chk("mstall_way", r_wsel, 1); chk("mstall_err", r_err, 0);

    // make both ways dirty, lru -> way 0
    txn(3'd1, 32'h000, 1, 0, 0, 0);
    chk("wr0_lat", r_lat, 3);
    txn(3'd1, 32'h384, 0, 1, 0, 0);
    chk("wr1_lat", r_lat, 3);

    // reset while the eviction request is pending
    @(negedge clk);
    cachereq_val = 1; cachereq_type = 3'd0; cachereq_addr = 32'h400;
    tag_match_0 = 0; tag_match_1 = 0; memreq_rdy = 0; cacheresp_rdy = 0;
    @(negedge clk); cachereq_val = 0;
    @(negedge clk);
    @(negedge clk);
    chk("evq_val", memreq_val, 1); chk("evq_type", memreq_type, 1);
    reset = 1;
    @(negedge clk);
    chk("abort_memreq", memreq_val, 0); chk("abort_resp", cacheresp_val, 0);
    reset = 0;

    // previously cached line must now miss
    txn(3'd0, 32'h000, 1, 0, 0, 0);
    chk("post_lat", r_lat, 6); chk("post_nreq", r_nreq, 1);
    chk("post_type", r_ty0, 0); chk("post_way", r_wsel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
